// File: rtl/fifo_axis_pkg.sv
// Shared types and constants for the FIFO-to-AXI-stream packetizer.
//   pkt_state_e : packet framing state (IDLE = between packets, ACTIVE = mid-packet)
//   SKID_DEPTH  : number of entries in the output skid buffer
package fifo_axis_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pkt_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_axis_skid.sv
// Two-entry valid/ready skid buffer, FIFO ordered.
//   clk, rst  : clock, async active-high reset
//   i_push    : write i_data this cycle (caller guarantees o_occ < 2)
//   i_data    : entry to store
//   i_ready   : downstream ready; pop happens on o_valid && i_ready
//   o_data    : head entry, stable while o_valid && !i_ready
//   o_valid   : buffer non-empty
//   o_occ     : current occupancy (0..2), used by the parent's read rule
module fifo_axis_skid
  import fifo_axis_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [SKID_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign w_pop   = o_valid && i_ready;
  // Entries never move once written, so the head stays stable during a stall.
  assign o_data  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fifo_axis_packetizer.sv
// Drains a first-word-fall-through FIFO into an AXI-stream master, framing
// words into packets of pkt_len beats (0 treated as 1) with m_tlast on the
// final beat. A 2-entry skid buffer decouples m_tready from fifo_r_en.
// Optional macro FIFO_AXIS_PARITY_EN adds m_tuser = XOR reduction of m_tdata.
//   clk, rst      : clock, async active-high reset
//   fifo_r_data   : FIFO head word;  fifo_empty : FIFO empty flag
//   fifo_r_en     : FIFO pop strobe (word captured on the same edge)
//   enable        : allows new packets to start
//   pkt_len       : beats per packet, sampled at each packet's first read
//   m_tdata/m_tvalid/m_tready/m_tlast : AXI-stream master
//   m_tuser       : beat parity (only with FIFO_AXIS_PARITY_EN)
//   busy          : packet in progress or skid buffer non-empty
//   pkt_count     : packets whose last beat was accepted (wraps)
module fifo_axis_packetizer
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN_W  = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic                  enable,
  input  logic [PKT_LEN_W-1:0]  pkt_len,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
`ifdef FIFO_AXIS_PARITY_EN
  output logic                  m_tuser,
`endif
  output logic                  busy,
  output logic [CNT_W-1:0]      pkt_count
);

`ifdef FIFO_AXIS_PARITY_EN
  localparam int ENT_W = DATA_WIDTH + 2;
`else
  localparam int ENT_W = DATA_WIDTH + 1;
`endif

  pkt_state_e           r_state;
  logic [PKT_LEN_W-1:0] r_len;
  logic [PKT_LEN_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0]     r_pkt_count;

  logic [PKT_LEN_W-1:0] w_len_in;
  logic                 w_last;
  logic                 w_rd_en;
  logic [1:0]           w_occ;
  logic [ENT_W-1:0]     w_push_ent;
  logic [ENT_W-1:0]     w_head;

  assign w_len_in = (pkt_len == '0) ? PKT_LEN_W'(1) : pkt_len;

  // Last-beat tag for the word being read this cycle.
  assign w_last = (r_state == IDLE) ? (w_len_in == PKT_LEN_W'(1))
                                    : (r_beat_cnt == r_len - PKT_LEN_W'(1));

  // Only registered state feeds the read strobe; m_tready never does.
  assign w_rd_en   = !rst && !fifo_empty && (w_occ < 2'd2) &&
                     ((r_state == ACTIVE) || enable);
  assign fifo_r_en = w_rd_en;

`ifdef FIFO_AXIS_PARITY_EN
  assign w_push_ent = {^fifo_r_data, w_last, fifo_r_data};
  assign m_tuser    = w_head[DATA_WIDTH+1];
`else
  assign w_push_ent = {w_last, fifo_r_data};
`endif

  fifo_axis_skid #(.W(ENT_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rd_en),
    .i_data  (w_push_ent),
    .i_ready (m_tready),
    .o_data  (w_head),
    .o_valid (m_tvalid),
    .o_occ   (w_occ)
  );

  assign m_tdata   = w_head[DATA_WIDTH-1:0];
  assign m_tlast   = m_tvalid && w_head[DATA_WIDTH];
  assign busy      = (r_state == ACTIVE) || (w_occ != 2'd0);
  assign pkt_count = r_pkt_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= PKT_LEN_W'(1);
      r_beat_cnt <= '0;
    end else if (w_rd_en) begin
      if (r_state == IDLE) begin
        r_len      <= w_len_in;
        r_beat_cnt <= PKT_LEN_W'(1);
        if (!w_last) r_state <= ACTIVE;
      end else begin
        r_beat_cnt <= r_beat_cnt + PKT_LEN_W'(1);
        if (w_last) r_state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pkt_count <= '0;
    else if (m_tvalid && m_tready && m_tlast) r_pkt_count <= r_pkt_count + CNT_W'(1);
  end

endmodule

// File: doc/fifo_axis_packetizer.md
Name: fifo_axis_packetizer

Overview:
- Downstream drain stage for the synchronous FIFO.
- Pops words through the FIFO's first-word-fall-through read port (r_data valid whenever empty is low) and presents them as an AXI-stream master.
- Groups words into packets of a programmable length and marks the final beat with m_tlast.
- A 2-entry output skid buffer gives full throughput with no combinational path from m_tready to fifo_r_en.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and m_tdata.
- PKT_LEN_W, 8, width of pkt_len; maximum packet length is 2^PKT_LEN_W-1 beats.
- CNT_W, 16, width of pkt_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_r_data  in  DATA_WIDTH  FIFO head word, combinational.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_en  out  1  FIFO pop strobe.
- enable  in  1  permits starting new packets.
- pkt_len  in  PKT_LEN_W  beats per packet, sampled at the first beat of each packet.
- m_tdata  out  DATA_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last beat of packet.
- busy  out  1  packet in progress or skid buffer non-empty.
- pkt_count  out  CNT_W  completed packets accepted downstream.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, pkt_count=0, skid occupancy=0, state=IDLE. fifo_r_en is forced 0 while rst is high.
- Read rule: fifo_r_en = !fifo_empty && (occ<2) && (state==ACTIVE || enable).
  - Depends only on registered state, never on m_tready.
  - fifo_r_data is captured into the skid buffer on the same edge as fifo_r_en.
- Latency: fifo_r_en high in cycle N gives m_tvalid high in cycle N+1.
- Throughput: with m_tready held high, one beat per cycle sustained.
- Skid buffer: 2 entries of {data, last}, FIFO ordered.
  - Push and pop in the same cycle leaves occ unchanged.
  - occ=2 blocks further reads.
  - m_tvalid = (occ!=0).
  - m_tdata/m_tlast come from the head entry and are held stable while m_tvalid && !m_tready.
- Packet state machine:
  - IDLE: on a read, latch len = (pkt_len==0 ? 1 : pkt_len) and set beat_cnt=1.
    - If len==1, the beat is tagged last and the state stays IDLE.
    - Otherwise go to ACTIVE.
  - ACTIVE: each read increments beat_cnt. On the read where beat_cnt==len-1 before increment, tag last and return to IDLE.
  - Back-to-back packets: the next read in IDLE starts a new packet, with no bubble.
- enable low:
  - An in-progress packet (ACTIVE) always completes.
  - No new packet starts while enable is low.
  - pkt_len changes mid-packet are ignored.
- FIFO empty mid-packet: reads stall and the beat count is preserved. The packet resumes when data arrives, and no tlast is forced.
- pkt_count increments on m_tvalid && m_tready && m_tlast and wraps modulo 2^CNT_W.
- busy = (state==ACTIVE) || (occ!=0).
- Reset mid-packet: skid contents are discarded and the partial packet is abandoned. The first read after reset starts a fresh packet.

Optional Feature:
- Macro: FIFO_AXIS_PARITY_EN.
- When defined:
  - Adds output m_tuser (1 bit), the even parity (XOR reduction) of the beat's data.
  - Parity is computed at capture, stored in the skid entry, and obeys the same stability rule as m_tdata.
  - Reset value is 0.
- When undefined: the port and storage are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_axis_pkg holds:
  - enum typedef pkt_state_e {IDLE, ACTIVE};
  - localparam SKID_DEPTH=2.
- Sub-module fifo_axis_skid: the 2-entry valid/ready buffer, parameterized on entry width.
  - Exposes occ to the parent for the read rule.
  - The parent holds the FSM, counters and pkt_count.

Test Plan:
- Write 0x1..0x8 to the FIFO, pkt_len=4, m_tready=1 -> 8 consecutive beats 0x1..0x8, m_tlast on 0x4 and 0x8, first m_tvalid one cycle after first fifo_r_en, pkt_count=2.
- 6 words queued, m_tready low for 5 cycles -> occ reaches 2 and fifo_r_en drops with 4 words still in the FIFO; data stable during the stall; after release, order 1..6 is intact and nothing is lost.
- pkt_len=0, 3 words -> every beat has m_tlast=1, pkt_count=3.
- pkt_len=4, enable dropped after beat 2 -> beats 3,4 still issue with tlast on 4, then no reads despite a non-empty FIFO; re-enable -> a new packet begins.
- FIFO runs dry after beat 2 of 4 for 10 cycles -> m_tvalid goes low, busy=1; two later words become beats 3,4 with tlast on beat 4.
- Assert rst with occ=2 mid-packet -> m_tvalid/busy/pkt_count=0 immediately; after release, the next word starts a new packet with tlast on its 4th beat.
